jtkcpu_stack_seq: RTL and testbench
===================================

# jtkcpu_stack_seq

Push/pull sequencer for the KCPU register file. Given a PSH/PUL postbyte, a U/S stack select and a direction, it walks the selected registers one byte at a time. For each byte it drives the register-select mask, the high/low byte select, the pointer decrement or pull-load strobes, and a byte-wide bus request. It sits between the instruction control unit and the register file/bus interface, and also serves interrupt entry (full push) and RTI (full pull).

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; all state changes qualified by cen
- start  in  1  begin sequence; sampled only in IDLE
- pull  in  1  1 = pull, 0 = push; latched at start
- ussel  in  1  1 = U stack, 0 = S stack; latched at start
- mask  in  8  postbyte, latched at start; bit0 CC, 1 A, 2 B, 3 DP, 4 X, 5 Y, 6 other stack, 7 PC
- bus_ack  in  1  byte transfer complete
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when sequence ends
- psh_sel  out  8  one-hot register being transferred (0 when idle)
- psh_hilon  out  1  1 = high byte of a 16-bit register
- psh_ussel  out  1  latched ussel
- pshdec  out  1  decrement stack pointer this cycle
- pul_en  out  1  load register from bus data this cycle, and post-increment the pointer
- bus_rd  out  1  read request
- bus_wr  out  1  write request
- nbytes  out  4  bytes transferred in this sequence, max 12

## Operation
- Reset: state IDLE. busy, done, pshdec, pul_en, bus_rd, bus_wr and psh_hilon are 0. psh_sel, psh_ussel and nbytes are 0.
- Byte list: CC, A, B, DP are 8-bit. X, Y, other-stack and PC are 16-bit (hi byte, then lo byte). An interrupt full push has 12 bytes.
- Pull order: ascending bit order. 16-bit registers go hi then lo. Sequence is CC, A, B, DP, Xh, Xl, Yh, Yl, Oh, Ol, PCh, PCl, skipping unselected registers.
- Push order: exact reverse of pull, so PCl is first and CC is last. Memory image is then big-endian and compatible with pull.
- State machine:
  - IDLE: on start with mask != 0, go to PSH_DEC (push) or PUL_RD (pull). On start with mask == 0, go to FIN.
  - PSH_DEC: assert pshdec for 1 cycle, then go to PSH_WR.
  - PSH_WR: hold bus_wr until bus_ack. On ack, nbytes++, advance to the next byte. Go to PSH_DEC, or to FIN after the last byte.
  - PUL_RD: hold bus_rd until bus_ack, then go to PUL_LD.
  - PUL_LD: assert pul_en for 1 cycle, nbytes++, advance. Go to PUL_RD, or to FIN after the last byte.
  - FIN: done = 1 for 1 cycle, busy = 0, return to IDLE.
- psh_sel and psh_hilon are stable through every cycle of a byte's DEC/WR or RD/LD pair.
- The remaining-byte tracker is a 12-bit pending vector derived from mask at start. The current byte is the lowest pending bit (pull) or highest pending bit (push). Each bit is cleared when its byte completes.
- start while busy: ignored; latched fields unchanged.
- bus_ack outside PSH_WR or PUL_RD: ignored.
- Reset mid-sequence: return to IDLE immediately with all outputs cleared. The pointer keeps any partial change; no recovery is attempted.
- mask bit 6 selects U when ussel = 0 and S when ussel = 1. The sequencer passes the selection through only.

## Timing
- All transitions occur on the rising clk edge with cen = 1. With cen = 0, state and outputs hold.
- start to first pshdec or bus_rd: 1 cen cycle.
- Push byte with immediate ack (ack in the first WR cycle): 2 cen cycles. Pull byte: 2 cen cycles.
- Total sequence latency: 1 + 2·N + 1 cycles, start to done, for N bytes. An empty mask gives 2 cycles: IDLE, then FIN.
- bus_ack low: the bus-request state stretches. The request stays high and psh_sel/psh_hilon stay unchanged.
- pul_en is asserted in the cycle after ack, so the register file samples data held by the bus interface.
- busy is high from the cycle after start until FIN, inclusive.
- A new start is accepted in the cycle after FIN.

## Structure
- Shared jtkcpu package/include: postbyte bit constants (PSH_CC … PSH_PC) and the state encodings.
- Single module; no sub-module.
- An optional priority encoder function (lowest/highest set bit of 12) is local to the module.

## Test plan
- Push, mask = 8'h81, ussel = 0, immediate acks. Expected: byte order PCl, PCh, CC. pshdec appears 3 times, bus_wr 3 times, nbytes = 3. done pulses exactly 8 cycles after start.
- Pull, mask = 8'hFF, ussel = 1, immediate acks. Expected: 12 pul_en pulses with psh_sel order 01, 02, 04, 08, 10 (hi, lo), 20 (hi, lo), 40 (hi, lo), 80 (hi, lo). nbytes = 12.
- Push, mask = 8'h10, bus_ack delayed 3 cycles per byte. Expected: bus_wr held 4 cycles each, psh_sel stable at 8'h10, total 12 cycles to done.
- mask = 8'h00, either direction. Expected: no bus_rd, bus_wr, pshdec or pul_en. done 2 cycles after start, nbytes = 0.
- cen toggling 1-0-1-0 during a pull of mask = 8'h06. Expected: outputs frozen during cen = 0 cycles. Same sequence as the all-ones cen run, but twice as long.
- rst_n asserted mid-push of mask = 8'hFF after 5 bytes. Expected: immediate IDLE, all outputs 0. A subsequent start, pull, mask = 8'h01 completes normally.

Source files
------------

// File: rtl/jtkcpu_stack_seq_pkg.sv
// Shared KCPU stack-sequencer definitions: postbyte bit positions,
// sequencer state encodings and the postbyte-to-byte-list expansion.
`timescale 1ns/1ps
package jtkcpu_stack_seq_pkg;

  localparam int PSH_CC = 0;
  localparam int PSH_A  = 1;
  localparam int PSH_B  = 2;
  localparam int PSH_DP = 3;
  localparam int PSH_X  = 4;
  localparam int PSH_Y  = 5;
  localparam int PSH_OS = 6;
  localparam int PSH_PC = 7;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PSH_DEC = 3'd1;
  localparam logic [2:0] ST_PSH_WR  = 3'd2;
  localparam logic [2:0] ST_PUL_RD  = 3'd3;
  localparam logic [2:0] ST_PUL_LD  = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  // One bit per byte in pull order: CC A B DP Xh Xl Yh Yl Oh Ol PCh PCl
  function automatic logic [11:0] expand_mask(
    input logic [7:0] m
  );
    expand_mask = {
      m[PSH_PC], m[PSH_PC],
      m[PSH_OS], m[PSH_OS],
      m[PSH_Y],  m[PSH_Y],
      m[PSH_X],  m[PSH_X],
      m[PSH_DP], m[PSH_B],
      m[PSH_A],  m[PSH_CC]
    };
  endfunction

endpackage

// File: rtl/jtkcpu_stack_seq.sv
// KCPU push/pull sequencer: walks the postbyte one stack byte
// at a time, driving register select, pointer strobes and bus requests.
`timescale 1ns/1ps
module jtkcpu_stack_seq
  import jtkcpu_stack_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       start,
  input  logic       pull,
  input  logic       ussel,
  input  logic [7:0] mask,
  input  logic       bus_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] psh_sel,
  output logic       psh_hilon,
  output logic       psh_ussel,
  output logic       pshdec,
  output logic       pul_en,
  output logic       bus_rd,
  output logic       bus_wr,
  output logic [3:0] nbytes
);

  logic [2:0]  st_q, st_d;
  logic [11:0] pend_q, pend_d;
  logic        pull_q, pull_d;
  logic        us_q, us_d;
  logic [3:0]  nb_q, nb_d;

  logic [3:0]  cur_idx;
  logic [11:0] pend_left;
  logic        active;
  logic [2:0]  reg_idx;

  function automatic logic [3:0] lo_bit(
    input logic [11:0] v
  );
    lo_bit = 4'd0;
    for (int i = 11; i >= 0; i--)
      if (v[i]) lo_bit = 4'(i);
  endfunction

  function automatic logic [3:0] hi_bit(
    input logic [11:0] v
  );
    hi_bit = 4'd0;
    for (int i = 0; i < 12; i++)
      if (v[i]) hi_bit = 4'(i);
  endfunction

  // Pull drains from the bottom of the list, push from the top
  assign cur_idx   = pull_q ? lo_bit(pend_q)
                            : hi_bit(pend_q);
  assign pend_left = pend_q & ~(12'd1 << cur_idx);

  assign active = (st_q == ST_PSH_DEC) ||
                  (st_q == ST_PSH_WR)  ||
                  (st_q == ST_PUL_RD)  ||
                  (st_q == ST_PUL_LD);

  // Bytes 4..11 are hi/lo pairs of registers 4..7
  assign reg_idx = (cur_idx < 4'd4) ? cur_idx[2:0]
                                    : cur_idx[3:1] + 3'd2;

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    pull_d = pull_q;
    us_d   = us_q;
    nb_d   = nb_q;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          pull_d = pull;
          us_d   = ussel;
          nb_d   = 4'd0;
          pend_d = expand_mask(mask);
          if (mask == 8'h00)
            st_d = ST_FIN;
          else if (pull)
            st_d = ST_PUL_RD;
          else
            st_d = ST_PSH_DEC;
        end
      end
      ST_PSH_DEC: st_d = ST_PSH_WR;
      ST_PSH_WR: begin
        if (bus_ack) begin
          pend_d = pend_left;
          nb_d   = nb_q + 4'd1;
          st_d   = (pend_left == 12'd0) ? ST_FIN
                                        : ST_PSH_DEC;
        end
      end
      ST_PUL_RD: begin
        if (bus_ack) st_d = ST_PUL_LD;
      end
      ST_PUL_LD: begin
        pend_d = pend_left;
        nb_d   = nb_q + 4'd1;
        st_d   = (pend_left == 12'd0) ? ST_FIN
                                      : ST_PUL_RD;
      end
      ST_FIN:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      pend_q <= 12'd0;
      pull_q <= 1'b0;
      us_q   <= 1'b0;
      nb_q   <= 4'd0;
    end else if (cen) begin
      st_q   <= st_d;
      pend_q <= pend_d;
      pull_q <= pull_d;
      us_q   <= us_d;
      nb_q   <= nb_d;
    end
  end

  assign busy      = (st_q != ST_IDLE);
  assign done      = (st_q == ST_FIN);
  assign pshdec    = (st_q == ST_PSH_DEC);
  assign bus_wr    = (st_q == ST_PSH_WR);
  assign bus_rd    = (st_q == ST_PUL_RD);
  assign pul_en    = (st_q == ST_PUL_LD);
  assign psh_sel   = active ? (8'd1 << reg_idx) : 8'd0;
  assign psh_hilon = active && (cur_idx >= 4'd4)
                            && !cur_idx[0];
  assign psh_ussel = us_q;
  assign nbytes    = nb_q;

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Self-checking bench for jtkcpu_stack_seq: per-cycle trace model
// built from the byte list, plus literal latency and count checks.
`timescale 1ns/1ps
module tb_jtkcpu_stack_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       start = 1'b0;
  logic       pull = 1'b0;
  logic       ussel = 1'b0;
  logic [7:0] mask = 8'h00;
  logic       bus_ack = 1'b0;
  logic       busy, done, psh_hilon, psh_ussel;
  logic       pshdec, pul_en, bus_rd, bus_wr;
  logic [7:0] psh_sel;
  logic [3:0] nbytes;

  jtkcpu_stack_seq dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .start(start), .pull(pull), .ussel(ussel),
    .mask(mask), .bus_ack(bus_ack),
    .busy(busy), .done(done),
    .psh_sel(psh_sel), .psh_hilon(psh_hilon),
    .psh_ussel(psh_ussel), .pshdec(pshdec),
    .pul_en(pul_en), .bus_rd(bus_rd),
    .bus_wr(bus_wr), .nbytes(nbytes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sel;
    logic       hi;
  } byte_t;
  typedef byte_t bq_t[$];

  typedef struct packed {
    logic       busy, done, pshdec, pul_en;
    logic       rd, wr, hi, us;
    logic [7:0] sel;
    logic [3:0] nb;
    logic       ack;
  } rec_t;

  int    errs = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;
  rec_t  exp_cur = '0;
  string cur_name = "reset";

  logic [19:0] act_vec;
  assign act_vec = {busy, done, pshdec, pul_en,
                    bus_rd, bus_wr, psh_hilon, psh_ussel,
                    psh_sel, nbytes};

  function automatic logic [19:0] pack(input rec_t r);
    pack = {r.busy, r.done, r.pshdec, r.pul_en,
            r.rd, r.wr, r.hi, r.us, r.sel, r.nb};
  endfunction

  function automatic rec_t mk(
    input bit b, d, pd, pe, rd, wr, hi, us, ak,
    input logic [7:0] s, input logic [3:0] nb
  );
    rec_t r;
    r.busy = b;  r.done = d;  r.pshdec = pd;
    r.pul_en = pe; r.rd = rd; r.wr = wr;
    r.hi = hi;  r.us = us;  r.ack = ak;
    r.sel = s;  r.nb = nb;
    return r;
  endfunction

  // Byte list straight from the register table; push is pull reversed
  function automatic bq_t build(
    input logic [7:0] m, input bit pl
  );
    bq_t   q;
    byte_t b;
    for (int r = 0; r < 8; r++) begin
      if (m[r]) begin
        b.sel = 8'(1 << r);
        if (r < 4) begin
          b.hi = 1'b0;
          if (pl) q.push_back(b); else q.push_front(b);
        end else begin
          b.hi = 1'b1;
          if (pl) q.push_back(b); else q.push_front(b);
          b.hi = 1'b0;
          if (pl) q.push_back(b); else q.push_front(b);
        end
      end
    end
    return q;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act_vec !== pack(exp_cur)) begin
        errs++;
        $display("FAIL %s t=%0t: got %b, expected %b",
                 cur_name, $time, act_vec, pack(exp_cur));
      end
    end
  end

  task automatic lit(
    input string nm, input logic [31:0] act, ex
  );
    checks++;
    if (act !== ex) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, ex);
    end
  endtask

  task automatic run_seq(
    input string nm, input bit pl, us,
    input logic [7:0] m, input int dly,
    input bit noise, ctog,
    input int abort_at, exp_cyc, exp_nb
  );
    bq_t  q;
    rec_t tr[$];
    int   n, idx, edges, done_at;
    q = build(m, pl);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      if (!pl) begin
        tr.push_back(mk(1,0,1,0,0,0,q[k].hi,us,noise,
                        q[k].sel,4'(k)));
        for (int j = 0; j <= dly; j++)
          tr.push_back(mk(1,0,0,0,0,1,q[k].hi,us,j==dly,
                          q[k].sel,4'(k)));
      end else begin
        for (int j = 0; j <= dly; j++)
          tr.push_back(mk(1,0,0,0,1,0,q[k].hi,us,j==dly,
                          q[k].sel,4'(k)));
        tr.push_back(mk(1,0,0,1,0,0,q[k].hi,us,noise,
                        q[k].sel,4'(k)));
      end
    end
    tr.push_back(mk(1,1,0,0,0,0,0,us,0,8'h00,4'(n)));
    tr.push_back(mk(0,0,0,0,0,0,0,us,0,8'h00,4'(n)));
    cur_name = nm;
    start = 1'b1; pull = pl; ussel = us; mask = m;
    cen = 1'b1; bus_ack = 1'b0;
    idx = -1; edges = 0; done_at = -1;
    forever begin
      @(posedge clk);
      edges++;
      if (cen) idx++;
      exp_cur = tr[idx];
      @(negedge clk);
      #1;
      if (done && done_at < 0) done_at = edges;
      if (idx == abort_at) begin
        rst_n = 1'b0;
        exp_cur = '0;
        #1;
        lit({nm, "_reset"}, 32'(act_vec), 32'd0);
        start = 1'b0; cen = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (idx == tr.size() - 1 || edges > 1000) break;
      start   = noise && !tr[idx].done;
      pull    = ~pl;
      ussel   = ~us;
      mask    = ~m;
      bus_ack = tr[idx].ack;
      cen     = ctog ? ~cen : 1'b1;
    end
    start = 1'b0; bus_ack = 1'b0; cen = 1'b1;
    lit({nm, "_finished"}, 32'(idx), 32'(tr.size() - 1));
    lit({nm, "_cycles"}, 32'(done_at + 1), 32'(exp_cyc));
    lit({nm, "_nbytes"}, 32'(nbytes), 32'(exp_nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t q;
    repeat (2) @(negedge clk);
    #1;
    exp_cur = '0;
    chk_en = 1'b1;
    lit("reset_outputs", 32'(act_vec), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    q = build(8'h81, 1'b0);
    lit("model_psh81_len", 32'(q.size()), 32'd3);
    lit("model_psh81_order",
        {5'd0, q[0], q[1], q[2]},
        {5'd0, 8'h80, 1'b0, 8'h80, 1'b1, 8'h01, 1'b0});
    q = build(8'hFF, 1'b1);
    lit("model_pulFF_len", 32'(q.size()), 32'd12);
    lit("model_pulFF_x_y",
        {14'd0, q[4], q[7]},
        {14'd0, 8'h10, 1'b1, 8'h20, 1'b0});

    run_seq("push81",  0, 0, 8'h81, 0, 1, 0, -1,  8,  3);
    run_seq("pullFF",  1, 1, 8'hFF, 0, 0, 0, -1, 26, 12);
    run_seq("push10d", 0, 0, 8'h10, 3, 1, 0, -1, 12,  2);
    run_seq("pull00",  1, 1, 8'h00, 0, 0, 0, -1,  2,  0);
    run_seq("push00",  0, 0, 8'h00, 0, 0, 0, -1,  2,  0);
    run_seq("pull06c", 1, 0, 8'h06, 0, 0, 1, -1, 10,  2);
    run_seq("pushFFr", 0, 0, 8'hFF, 0, 0, 0, 10,  0,  0);
    run_seq("pull01",  1, 0, 8'h01, 0, 0, 0, -1,  4,  1);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
